// File: rtl/fifo_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ClockReset (interface)
// Description : Bundles the single clock and its synchronous active-high
//               reset so blocks can take them as one port.
//               client modport : clk (in), reset (in)
// Revision    : 1.0 - initial release
// ============================================================================
interface ClockReset;
  logic clk;
  logic reset;

  modport client (input clk, input reset);
endinterface : ClockReset
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rr_arbiter
// Description : Round-robin arbiter that merges num_ports ready/enable
//               streams into one stream feeding a sync FIFO write port.
//               A grant lasts at most `burst` beats, or until the granted
//               requester drops in_enable. One IDLE cycle separates grants.
// Ports       : cr          - ClockReset.client (clk, synchronous reset)
//               in_enable   - per-requester data valid      [num_ports]
//               in_ready    - per-requester accept          [num_ports]
//               in_data     - requester k at [k*width +: width]
//               out_enable  - output beat valid
//               out_ready   - downstream accept
//               out_data    - data of the granted requester [width]
//               out_source  - index of the granted requester
//               beat_count  - per-requester 16-bit transfer counters, only
//                             present when FIFO_RR_ARBITER_STATS_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter #(
  parameter int width     = 8,
  parameter int num_ports = 4,
  parameter int burst     = 4
) (
  ClockReset.client                      cr,
  input  logic [num_ports-1:0]           in_enable,
  output logic [num_ports-1:0]           in_ready,
  input  logic [num_ports*width-1:0]     in_data,
  output logic                           out_enable,
  input  logic                           out_ready,
  output logic [width-1:0]               out_data,
  output logic [$clog2(num_ports)-1:0]   out_source
`ifdef FIFO_RR_ARBITER_STATS_EN
  ,
  output logic [num_ports*16-1:0]        beat_count
`endif
);

  localparam int                  c_src_w     = $clog2(num_ports);
  localparam int                  c_beat_w    = $clog2(burst) + 1;
  localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(burst - 1);
  // last starts at the highest index so the first search begins at port 0
  localparam logic [c_src_w-1:0]  c_last_rst  = c_src_w'(num_ports - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [c_src_w-1:0]  grant_q, grant_d;
  logic [c_src_w-1:0]  last_q,  last_d;
  logic [c_beat_w-1:0] beat_q,  beat_d;

  logic [width-1:0]    w_word [num_ports];
  logic [c_src_w-1:0]  w_arb_pick;
  logic [c_src_w-1:0]  w_arb_idx;
  logic                w_arb_found;
  logic                w_req;

  generate
    for (genvar k = 0; k < num_ports; k++) begin : g_unpack
      assign w_word[k] = in_data[k*width +: width];
    end
  endgenerate

  assign w_req = in_enable[grant_q];

  // Round-robin search: first enabled requester after `last`, with wrap.
  always_comb begin
    w_arb_pick  = last_q;
    w_arb_idx   = '0;
    w_arb_found = 1'b0;
    for (int i = 1; i <= num_ports; i++) begin
      w_arb_idx = c_src_w'((int'(last_q) + i) % num_ports);
      if (!w_arb_found && in_enable[w_arb_idx]) begin
        w_arb_pick  = w_arb_idx;
        w_arb_found = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (|in_enable) begin
          grant_d = w_arb_pick;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!w_req) begin
          // requester went away: release without a transfer
          last_d  = grant_q;
          state_d = IDLE;
        end else if (out_ready) begin
          if (beat_q == c_beat_last) begin
            last_d  = grant_q;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; reset forces everything quiet in the same cycle so an
  // in-flight beat is aborted rather than transferred.
  always_comb begin
    out_enable = 1'b0;
    in_ready   = '0;
    out_data   = '0;
    out_source = '0;
    if (state_q == GRANT && !cr.reset) begin
      out_enable        = w_req;
      out_data          = w_word[grant_q];
      out_source        = grant_q;
      in_ready[grant_q] = out_ready;
    end
  end

  always_ff @(posedge cr.clk) begin
    if (cr.reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= c_last_rst;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

`ifdef FIFO_RR_ARBITER_STATS_EN
  // in_ready is only ever high for the granted port, so this is the
  // per-port transfer strobe.
  logic [num_ports-1:0] w_fire;
  assign w_fire = in_enable & in_ready;

  generate
    for (genvar k = 0; k < num_ports; k++) begin : g_stats
      logic [15:0] cnt_q;
      always_ff @(posedge cr.clk) begin
        if (cr.reset) begin
          cnt_q <= '0;
        end else if (w_fire[k]) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      assign beat_count[k*16 +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule : fifo_rr_arbiter
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rr_arbiter
// Description : Self-checking bench for fifo_rr_arbiter. A transaction-level
//               model tracks which requester owns the output and how many
//               beats it has moved; directed scenarios pin exact beat
//               order, data and timing with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  ClockReset cr_if ();

  logic [N-1:0]   in_enable;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_enable;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_source;
`ifdef FIFO_RR_ARBITER_STATS_EN
  logic [N*16-1:0] beat_count;
`endif

  fifo_rr_arbiter #(.width(W), .num_ports(N), .burst(B)) dut (
    .cr         (cr_if),
    .in_enable  (in_enable),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_enable (out_enable),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_source (out_source)
`ifdef FIFO_RR_ARBITER_STATS_EN
    ,
    .beat_count (beat_count)
`endif
  );

  initial cr_if.clk = 1'b0;
  always #5 cr_if.clk = ~cr_if.clk;

  int checks = 0;
  int errors = 0;

  // requester sources: beats remaining and next data byte per port
  int           rem [N];
  logic [7:0]   nxt [N];
  logic [N-1:0] fire_q = '0;

  // model: owner = -1 when nobody holds the output
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = N - 1;
  int m_tot [N];
  int m_c;
  bit chk_en  = 1'b0;

  int cyc = 0;
  int log_src [$];
  int log_dat [$];
  int log_cyc [$];

  always @(posedge cr_if.clk) begin
    cyc++;
    if (cr_if.reset) begin
      m_owner = -1;
      m_beats = 0;
      m_last  = N - 1;
      for (int p = 0; p < N; p++) m_tot[p] = 0;
    end else if (m_owner < 0) begin
      if (in_enable != '0) begin
        for (int i = 1; i <= N; i++) begin
          m_c = (m_last + i) % N;
          if (in_enable[m_c]) begin
            m_owner = m_c;
            break;
          end
        end
        m_beats = 0;
      end
    end else if (!in_enable[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (out_ready) begin
      m_tot[m_owner]++;
      m_beats++;
      if (m_beats == B) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  logic         e_en;
  logic [N-1:0] e_rdy;
  logic [W-1:0] e_dat;
  logic [1:0]   e_src;

  always @(negedge cr_if.clk) begin
    fire_q = in_enable & in_ready;
    if (chk_en) begin
      e_en  = 1'b0;
      e_rdy = '0;
      e_dat = '0;
      e_src = '0;
      if (!cr_if.reset && m_owner >= 0) begin
        e_en           = in_enable[m_owner];
        e_dat          = in_data[m_owner*W +: W];
        e_src          = 2'(m_owner);
        e_rdy[m_owner] = out_ready;
      end
      checks++;
      if (out_enable !== e_en || in_ready !== e_rdy || out_data !== e_dat || out_source !== e_src) begin
        errors++;
        $display("FAIL model_cycle%0d: got en=%b rdy=%b src=%0d data=%h, want en=%b rdy=%b src=%0d data=%h",
                 cyc, out_enable, in_ready, out_source, out_data, e_en, e_rdy, e_src, e_dat);
      end
      if (!cr_if.reset && out_enable && out_ready) begin
        log_src.push_back(int'(out_source));
        log_dat.push_back(int'(out_data));
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      in_enable[p]      = (rem[p] > 0);
      in_data[p*W +: W] = nxt[p];
    end
  endtask

  task automatic tick();
    @(posedge cr_if.clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (fire_q[p] && rem[p] > 0) begin
        nxt[p]++;
        rem[p]--;
      end
    end
    drive();
  endtask

  task automatic wait_log(input int n, input string name);
    int budget;
    budget = 40;
    while (log_src.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    chk(name, log_src.size() >= n, 1);
  endtask

  task automatic do_reset();
    cr_if.reset = 1'b1;
    out_ready   = 1'b1;
    for (int p = 0; p < N; p++) begin
      rem[p] = 0;
      nxt[p] = '0;
    end
    drive();
    tick();
    chk_en = 1'b1;
    tick();
    #1;
    chk("rst_out_enable", out_enable, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_source", out_source, 0);
    chk("rst_out_data", out_data, 0);
    cr_if.reset = 1'b0;
    log_src.delete();
    log_dat.delete();
    log_cyc.delete();
  endtask

  initial begin
    cr_if.reset = 1'b1;
    in_enable   = '0;
    in_data     = '0;
    out_ready   = 1'b1;

    // Reset state and the cycle directly after reset
    do_reset();
    tick();
    #1;
    chk("post_rst_out_enable", out_enable, 0);
    chk("post_rst_in_ready", in_ready, 0);
    chk("post_rst_out_source", out_source, 0);

    // Single requester, 6 beats: 4-beat burst, one IDLE cycle, 2 beats
    do_reset();
    rem[2] = 6;
    nxt[2] = 8'hA0;
    drive();
    repeat (12) tick();
    chk("single_count", log_src.size(), 6);
    if (log_src.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("single_src%0d", i), log_src[i], 2);
        chk($sformatf("single_dat%0d", i), log_dat[i], 8'hA0 + i);
      end
      chk("single_in_burst_gap", log_cyc[3] - log_cyc[0], 3);
      chk("single_idle_gap", log_cyc[4] - log_cyc[3], 2);
    end

    // All requesters busy: order 0,1,2,3,0, 4 beats each, 1 IDLE between
    do_reset();
    for (int p = 0; p < N; p++) begin
      rem[p] = 200;
      nxt[p] = 8'(p * 16);
    end
    drive();
    repeat (26) tick();
    chk("rr_count_ge20", log_src.size() >= 20, 1);
    if (log_src.size() >= 20) begin
      for (int i = 0; i < 20; i++) begin
        chk($sformatf("rr_src%0d", i), log_src[i], (i / 4) % 4);
        chk($sformatf("rr_dat%0d", i), log_dat[i], ((i / 4) % 4) * 16 + (i / 16) * 4 + (i % 4));
      end
      chk("rr_gap_0_1", log_cyc[4] - log_cyc[3], 2);
      chk("rr_gap_3_0", log_cyc[16] - log_cyc[15], 2);
    end

    // Downstream stall mid-burst on port 1
    do_reset();
    rem[1] = 8;
    nxt[1] = 8'h50;
    drive();
    wait_log(2, "stall_wait_two_beats");
    out_ready = 1'b0;
    repeat (10) begin
      #1;
      chk("stall_in_ready1", in_ready[1], 0);
      chk("stall_out_enable", out_enable, 1);
      chk("stall_out_data", out_data, 8'h52);
      tick();
    end
    out_ready = 1'b1;
    repeat (12) tick();
    chk("stall_count", log_src.size(), 8);
    if (log_src.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("stall_src%0d", i), log_src[i], 1);
        chk($sformatf("stall_dat%0d", i), log_dat[i], 8'h50 + i);
      end
    end

    // Port 3 drops after 2 beats; next grant wraps to port 0, then port 1
    do_reset();
    rem[3] = 2;
    nxt[3] = 8'h30;
    drive();
    wait_log(1, "drop_wait_first_beat");
    rem[0] = 2;
    nxt[0] = 8'h00;
    rem[1] = 2;
    nxt[1] = 8'h10;
    drive();
    repeat (15) tick();
    chk("drop_count", log_src.size(), 6);
    if (log_src.size() == 6) begin
      chk("drop_src0", log_src[0], 3);
      chk("drop_src1", log_src[1], 3);
      chk("drop_src2", log_src[2], 0);
      chk("drop_src3", log_src[3], 0);
      chk("drop_src4", log_src[4], 1);
      chk("drop_src5", log_src[5], 1);
      chk("drop_dat1", log_dat[1], 8'h31);
      chk("drop_dat2", log_dat[2], 8'h00);
      chk("drop_dat4", log_dat[4], 8'h10);
    end

    // Reset pulse during beat 2 of port 0
    do_reset();
    rem[0] = 8;
    nxt[0] = 8'h00;
    rem[1] = 8;
    nxt[1] = 8'h10;
    drive();
    wait_log(2, "rstmid_wait_two_beats");
    cr_if.reset = 1'b1;
    #1;
    chk("rstmid_out_enable", out_enable, 0);
    chk("rstmid_in_ready", in_ready, 0);
    tick();
    cr_if.reset = 1'b0;
    #1;
    chk("rstmid_idle_out_enable", out_enable, 0);
    chk("rstmid_idle_in_ready", in_ready, 0);
    repeat (4) tick();
    chk("rstmid_count_ge3", log_src.size() >= 3, 1);
    if (log_src.size() >= 3) begin
      chk("rstmid_src2", log_src[2], 0);
      chk("rstmid_dat2", log_dat[2], 8'h02);
    end

`ifdef FIFO_RR_ARBITER_STATS_EN
    // Transfer counters against the model's per-port totals
    do_reset();
    for (int p = 0; p < N; p++) begin
      rem[p] = 200;
      nxt[p] = 8'(p * 16);
    end
    drive();
    repeat (40) tick();
    #1;
    for (int p = 0; p < N; p++) begin
      chk($sformatf("stats_port%0d", p), int'(beat_count[p*16 +: 16]), m_tot[p]);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_fifo_rr_arbiter
`default_nettype wire

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 SHALL have parameter width, default 8: data bits per beat.
REQ-002 SHALL have parameter num_ports, default 4: number of requesters, 2..16.
REQ-003 SHALL have parameter burst, default 4: maximum beats per grant, at least 1.
REQ-004 SHALL have port cr.clk, input (ClockReset.client), 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port cr.reset, input (ClockReset.client), 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_enable, input, num_ports bits: per-requester data-valid.
REQ-007 SHALL have port in_ready, output, num_ports bits: per-requester accept.
REQ-008 SHALL have port in_data, input, num_ports*width bits: requester k occupies bits [k*width +: width].
REQ-009 SHALL have port out_enable, output, 1 bit: output data valid; feeds the enable of a downstream sync FIFO write port.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-011 SHALL have port out_data, output, width bits: data of the granted requester.
REQ-012 SHALL have port out_source, output, $clog2(num_ports) bits: index of the granted requester.

Function
REQ-013 SHALL define one transfer as any cycle with enable and ready both high on the same side; the output side and the granted input side transfer in the same cycle.
REQ-014 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-015 IDLE behaviour:
- out_enable=0 and in_ready=0.
- If any in_enable bit is high, latch grant = first requester k with in_enable[k]=1, searching from (last+1) mod num_ports upward with wrap.
- Clear beat counter and go to GRANT next cycle (arbitration latency 1 cycle).
REQ-016 GRANT combinational outputs:
- out_enable = in_enable[grant]; out_data = in_data[grant]; out_source = grant.
- in_ready[grant] = out_ready; all other in_ready bits 0.
REQ-017 GRANT release: on a transfer with beat counter = burst-1, set last=grant and go to IDLE.
REQ-018 GRANT, transfer with beat counter < burst-1: increment beat counter and stay in GRANT.
REQ-019 GRANT, in_enable[grant]=0: set last=grant and go to IDLE; no beat transfers.
REQ-020 GRANT, out_ready=0 with in_enable[grant]=1: hold the grant indefinitely, with no timeout.
REQ-021 Beat counter SHALL be $clog2(burst)+1 bits and never exceed burst-1.
REQ-022 When burst=1, every grant SHALL release after exactly one transfer.
REQ-023 Requests from non-granted ports SHALL be ignored until the next IDLE cycle; no data is lost, because their in_ready stays 0.
REQ-024 Every requester with in_enable held high SHALL be granted within num_ports arbitration rounds (starvation-free).

Reset
REQ-025 While cr.reset is high the block SHALL go to IDLE, with grant=0, beat counter=0 and last=num_ports-1, so port 0 has first priority.
REQ-026 Outputs during and directly after reset SHALL be out_enable=0, in_ready=0, out_source=0, out_data=0.
REQ-027 Reset asserted mid-burst SHALL abort the grant immediately, with no transfer in that cycle.

Configuration
REQ-028 Macro FIFO_RR_ARBITER_STATS_EN, when defined, SHALL add output beat_count (num_ports*16 bits): per-requester transfer counters, cleared by reset, incremented on each transfer, wrapping at 65535->0.
REQ-029 Without FIFO_RR_ARBITER_STATS_EN the beat_count port and its counters SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Only port 2 enabled, 6 beats 0xA0..0xA5, out_ready=1 ->
- Beats A0..A3 leave with out_source=2.
- One IDLE cycle, then A4..A5 leave.
REQ-031 All 4 ports continuously enabled, out_ready=1 ->
- Grant order 0,1,2,3,0.
- Each grant is 4 beats followed by 1 IDLE cycle.
REQ-032 Port 1 granted, out_ready low for 10 cycles mid-burst ->
- in_ready[1]=0 and out_data stable throughout.
- Burst resumes with no beat lost or duplicated.
REQ-033 Port 3 drops in_enable after 2 beats ->
- Grant released.
- Next grant goes to the lowest enabled port after 3, with wrap to 0.
REQ-034 cr.reset pulsed during beat 2 of port 0 ->
- Next cycle is IDLE.
- After reset, port 0 wins first, ahead of port 1 also requesting.
REQ-035 With FIFO_RR_ARBITER_STATS_EN defined, run REQ-031 for 40 cycles -> beat_count equals the per-port transfer totals counted by the bench scoreboard.
